// File: rtl/sd_regs_bus.sv
// SD controller host register bank: byte-lane access at 8/16/32-bit bus width,
// staged argument commit, response snapshots, W1C interrupt status and registered irq.
module sd_regs_bus #(
   parameter int          BUS_W             = 8,
   parameter int          CMD_W             = 14,
   parameter int          CMD_TIMEOUT_W     = 24,
   parameter int          DATA_TIMEOUT_W    = 24,
   parameter int          BLKSIZE_W         = 12,
   parameter int          BLKCNT_W          = 16,
   parameter int          INT_CMD_W         = 5,
   parameter int          INT_DATA_W        = 3,
   parameter int          RESET_BLOCK_SIZE  = 512,
   parameter int          SUPPLY_VOLTAGE_MV = 3300,
   parameter logic [15:0] CAPABILITIES      = 16'h0000
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      we_i,
   input  logic                      re_i,
   input  logic [6:0]                addr_i,
   input  logic [BUS_W-1:0]          data_in_i,
   output logic [BUS_W-1:0]          data_out_o,
   input  logic                      cmd_busy_i,
   input  logic [31:0]               response_0_i,
   input  logic [31:0]               response_1_i,
   input  logic [31:0]               response_2_i,
   input  logic [31:0]               response_3_i,
   input  logic [INT_CMD_W-1:0]      cmd_int_evt_i,
   input  logic [INT_DATA_W-1:0]     data_int_evt_i,
   output logic [31:0]               argument_reg_o,
   output logic [CMD_W-1:0]          command_reg_o,
   output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_reg_o,
   output logic [DATA_TIMEOUT_W-1:0] data_timeout_reg_o,
   output logic [BLKSIZE_W-1:0]      block_size_reg_o,
   output logic [BLKCNT_W-1:0]       block_count_reg_o,
   output logic [7:0]                clock_divider_reg_o,
   output logic                      controll_setting_reg_o,
   output logic                      software_reset_reg_o,
   output logic                      cmd_start_o,
   output logic                      cmd_int_rst_o,
   output logic                      data_int_rst_o,
   output logic                      irq_o
);
   localparam int LANES = BUS_W / 8;

   localparam logic [4:0] W_ARG    = 5'd0;
   localparam logic [4:0] W_CMD    = 5'd1;
   localparam logic [4:0] W_RESP0  = 5'd2;
   localparam logic [4:0] W_RESP1  = 5'd3;
   localparam logic [4:0] W_RESP2  = 5'd4;
   localparam logic [4:0] W_RESP3  = 5'd5;
   localparam logic [4:0] W_DTO    = 5'd6;
   localparam logic [4:0] W_CTRL   = 5'd7;
   localparam logic [4:0] W_CTO    = 5'd8;
   localparam logic [4:0] W_CLKD   = 5'd9;
   localparam logic [4:0] W_SWRST  = 5'd10;
   localparam logic [4:0] W_VOLT   = 5'd11;
   localparam logic [4:0] W_CAPA   = 5'd12;
   localparam logic [4:0] W_CISR   = 5'd13;
   localparam logic [4:0] W_CISER  = 5'd14;
   localparam logic [4:0] W_DISR   = 5'd15;
   localparam logic [4:0] W_DISER  = 5'd16;
   localparam logic [4:0] W_BLKSZ  = 5'd17;
   localparam logic [4:0] W_BLKCNT = 5'd18;

   logic [6:0]  base;
   logic [4:0]  word;
   logic [1:0]  off;
   logic [3:0]  wbe;
   logic [31:0] wdat;
   logic [31:0] wmask;

   logic [31:0]               stage_q, stage_d;
   logic [31:0]               argument_q, argument_d;
   logic [CMD_W-1:0]          command_q, command_d;
   logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_q, cmd_timeout_d;
   logic [DATA_TIMEOUT_W-1:0] data_timeout_q, data_timeout_d;
   logic [BLKSIZE_W-1:0]      block_size_q, block_size_d;
   logic [BLKCNT_W-1:0]       block_count_q, block_count_d;
   logic [7:0]                clock_div_q, clock_div_d;
   logic                      ctrl_q, ctrl_d;
   logic                      swrst_q, swrst_d;
   logic [INT_CMD_W-1:0]      cmd_isr_q, cmd_isr_d;
   logic [INT_CMD_W-1:0]      cmd_iser_q, cmd_iser_d;
   logic [INT_DATA_W-1:0]     data_isr_q, data_isr_d;
   logic [INT_DATA_W-1:0]     data_iser_q, data_iser_d;
   logic [31:0]               snap_q, snap_d;
   logic [BUS_W-1:0]          data_out_q, data_out_d;
   logic                      irq_q, irq_d;
   logic                      cmd_start_q, cmd_start_d;
   logic                      cmd_int_rst_q, cmd_int_rst_d;
   logic                      data_int_rst_q, data_int_rst_d;

   logic wr_arg, wr_cmd, wr_dto, wr_ctrl, wr_cto, wr_clkd, wr_swrst;
   logic wr_cisr, wr_ciser, wr_disr, wr_diser, wr_blksz, wr_blkcnt;
   logic commit;
   logic is_resp;
   logic [31:0] resp_live;
   logic [31:0] rword;

   // Lanes of one access always land in the same 32-bit word because the address is lane-aligned.
   assign base = addr_i & ~7'(LANES - 1);
   assign word = base[6:2];
   assign off  = base[1:0];

   always_comb begin
      wbe  = '0;
      wdat = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (2'(b) == off + 2'(k)) begin
               wbe[b]         = 1'b1;
               wdat[8*b +: 8] = data_in_i[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      wmask = '0;
      for (int b = 0; b < 4; b++) begin
         wmask[8*b +: 8] = {8{wbe[b]}};
      end
   end

   assign wr_arg    = we_i && (word == W_ARG);
   assign wr_cmd    = we_i && (word == W_CMD);
   assign wr_dto    = we_i && (word == W_DTO);
   assign wr_ctrl   = we_i && (word == W_CTRL);
   assign wr_cto    = we_i && (word == W_CTO);
   assign wr_clkd   = we_i && (word == W_CLKD);
   assign wr_swrst  = we_i && (word == W_SWRST);
   assign wr_cisr   = we_i && (word == W_CISR);
   assign wr_ciser  = we_i && (word == W_CISER);
   assign wr_disr   = we_i && (word == W_DISR);
   assign wr_diser  = we_i && (word == W_DISER);
   assign wr_blksz  = we_i && (word == W_BLKSZ);
   assign wr_blkcnt = we_i && (word == W_BLKCNT);

   // Argument reaches the core only when byte 3 is written, so multi-access updates stay atomic.
   assign commit = wr_arg && wbe[3];

   always_comb begin
      stage_d        = stage_q;
      argument_d     = argument_q;
      command_d      = command_q;
      cmd_timeout_d  = cmd_timeout_q;
      data_timeout_d = data_timeout_q;
      block_size_d   = block_size_q;
      block_count_d  = block_count_q;
      clock_div_d    = clock_div_q;
      ctrl_d         = ctrl_q;
      swrst_d        = swrst_q;
      cmd_iser_d     = cmd_iser_q;
      data_iser_d    = data_iser_q;
      if (wr_arg) stage_d = (stage_q & ~wmask) | (wdat & wmask);
      if (commit) argument_d = stage_d;
      if (wr_cmd)
         command_d = (command_q & ~wmask[CMD_W-1:0]) | (wdat[CMD_W-1:0] & wmask[CMD_W-1:0]);
      if (wr_cto)
         cmd_timeout_d = (cmd_timeout_q & ~wmask[CMD_TIMEOUT_W-1:0])
                       | (wdat[CMD_TIMEOUT_W-1:0] & wmask[CMD_TIMEOUT_W-1:0]);
      if (wr_dto)
         data_timeout_d = (data_timeout_q & ~wmask[DATA_TIMEOUT_W-1:0])
                        | (wdat[DATA_TIMEOUT_W-1:0] & wmask[DATA_TIMEOUT_W-1:0]);
      if (wr_blksz)
         block_size_d = (block_size_q & ~wmask[BLKSIZE_W-1:0])
                      | (wdat[BLKSIZE_W-1:0] & wmask[BLKSIZE_W-1:0]);
      if (wr_blkcnt)
         block_count_d = (block_count_q & ~wmask[BLKCNT_W-1:0])
                       | (wdat[BLKCNT_W-1:0] & wmask[BLKCNT_W-1:0]);
      if (wr_clkd)  clock_div_d = (clock_div_q & ~wmask[7:0]) | (wdat[7:0] & wmask[7:0]);
      if (wr_ctrl)  ctrl_d  = (ctrl_q & ~wmask[0]) | (wdat[0] & wmask[0]);
      if (wr_swrst) swrst_d = (swrst_q & ~wmask[0]) | (wdat[0] & wmask[0]);
      if (wr_ciser)
         cmd_iser_d = (cmd_iser_q & ~wmask[INT_CMD_W-1:0]) | (wdat[INT_CMD_W-1:0] & wmask[INT_CMD_W-1:0]);
      if (wr_diser)
         data_iser_d = (data_iser_q & ~wmask[INT_DATA_W-1:0])
                     | (wdat[INT_DATA_W-1:0] & wmask[INT_DATA_W-1:0]);
   end

   // A new event in the same cycle as its clear keeps the bit set.
   always_comb begin
      cmd_isr_d  = cmd_isr_q;
      data_isr_d = data_isr_q;
      if (wr_cisr) cmd_isr_d  = cmd_isr_q & ~(wdat[INT_CMD_W-1:0] & wmask[INT_CMD_W-1:0]);
      if (wr_disr) data_isr_d = data_isr_q & ~(wdat[INT_DATA_W-1:0] & wmask[INT_DATA_W-1:0]);
      cmd_isr_d  = cmd_isr_d | cmd_int_evt_i;
      data_isr_d = data_isr_d | data_int_evt_i;
   end

   assign irq_d          = (|(cmd_isr_q & cmd_iser_q)) || (|(data_isr_q & data_iser_q));
   assign cmd_start_d    = commit && !cmd_busy_i;
   assign cmd_int_rst_d  = wr_cisr;
   assign data_int_rst_d = wr_disr;

   assign is_resp = (word >= W_RESP0) && (word <= W_RESP3);

   always_comb begin
      resp_live = 32'h0;
      case (word)
         W_RESP0: resp_live = response_0_i;
         W_RESP1: resp_live = response_1_i;
         W_RESP2: resp_live = response_2_i;
         W_RESP3: resp_live = response_3_i;
         default: resp_live = 32'h0;
      endcase
   end

   // Reading byte 0 freezes the whole response so the upper bytes read later stay coherent.
   assign snap_d = (re_i && is_resp && (off == 2'd0)) ? resp_live : snap_q;

   always_comb begin
      rword = 32'h0;
      case (word)
         W_ARG:    rword = argument_q;
         W_CMD:    rword = 32'(command_q);
         W_RESP0, W_RESP1, W_RESP2, W_RESP3:
                   rword = (off == 2'd0) ? resp_live : snap_q;
         W_DTO:    rword = 32'(data_timeout_q);
         W_CTRL:   rword = 32'(ctrl_q);
         W_CTO:    rword = 32'(cmd_timeout_q);
         W_CLKD:   rword = 32'(clock_div_q);
         W_SWRST:  rword = 32'(swrst_q);
         W_VOLT:   rword = 32'(SUPPLY_VOLTAGE_MV);
         W_CAPA:   rword = 32'(CAPABILITIES);
         W_CISR:   rword = 32'(cmd_isr_q);
         W_CISER:  rword = 32'(cmd_iser_q);
         W_DISR:   rword = 32'(data_isr_q);
         W_DISER:  rword = 32'(data_iser_q);
         W_BLKSZ:  rword = 32'(block_size_q);
         W_BLKCNT: rword = 32'(block_count_q);
         default:  rword = 32'h0;
      endcase
   end

   always_comb begin
      data_out_d = data_out_q;
      if (re_i) begin
         for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (2'(b) == off + 2'(k)) data_out_d[8*k +: 8] = rword[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q        <= '0;
         argument_q     <= '0;
         command_q      <= '0;
         cmd_timeout_q  <= '0;
         data_timeout_q <= '0;
         block_size_q   <= BLKSIZE_W'(RESET_BLOCK_SIZE);
         block_count_q  <= '0;
         clock_div_q    <= 8'd1;
         ctrl_q         <= 1'b0;
         swrst_q        <= 1'b0;
         cmd_isr_q      <= '0;
         cmd_iser_q     <= '0;
         data_isr_q     <= '0;
         data_iser_q    <= '0;
         snap_q         <= '0;
         data_out_q     <= '0;
         irq_q          <= 1'b0;
         cmd_start_q    <= 1'b0;
         cmd_int_rst_q  <= 1'b0;
         data_int_rst_q <= 1'b0;
      end else begin
         stage_q        <= stage_d;
         argument_q     <= argument_d;
         command_q      <= command_d;
         cmd_timeout_q  <= cmd_timeout_d;
         data_timeout_q <= data_timeout_d;
         block_size_q   <= block_size_d;
         block_count_q  <= block_count_d;
         clock_div_q    <= clock_div_d;
         ctrl_q         <= ctrl_d;
         swrst_q        <= swrst_d;
         cmd_isr_q      <= cmd_isr_d;
         cmd_iser_q     <= cmd_iser_d;
         data_isr_q     <= data_isr_d;
         data_iser_q    <= data_iser_d;
         snap_q         <= snap_d;
         data_out_q     <= data_out_d;
         irq_q          <= irq_d;
         cmd_start_q    <= cmd_start_d;
         cmd_int_rst_q  <= cmd_int_rst_d;
         data_int_rst_q <= data_int_rst_d;
      end
   end

   assign data_out_o             = data_out_q;
   assign argument_reg_o         = argument_q;
   assign command_reg_o          = command_q;
   assign cmd_timeout_reg_o      = cmd_timeout_q;
   assign data_timeout_reg_o     = data_timeout_q;
   assign block_size_reg_o       = block_size_q;
   assign block_count_reg_o      = block_count_q;
   assign clock_divider_reg_o    = clock_div_q;
   assign controll_setting_reg_o = ctrl_q;
   assign software_reset_reg_o   = swrst_q;
   assign cmd_start_o            = cmd_start_q;
   assign cmd_int_rst_o          = cmd_int_rst_q;
   assign data_int_rst_o         = data_int_rst_q;
   assign irq_o                  = irq_q;

endmodule

// File: tb/tb_sd_regs_bus.sv
// Bench for sd_regs_bus: an 8-bit and a 32-bit instance driven side by side,
// each checked every cycle against a byte-level reference model through a scoreboard queue.
module tb_sd_regs_bus;
   typedef struct packed {
      logic [31:0] dout;
      logic [31:0] arg;
      logic [13:0] cmd;
      logic [23:0] cto;
      logic [23:0] dto;
      logic [11:0] bs;
      logic [15:0] bc;
      logic [7:0]  cd;
      logic        ctl;
      logic        swr;
      logic        cst;
      logic        cir;
      logic        dir;
      logic        irq;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        we_r   [2];
   logic        re_r   [2];
   logic [6:0]  addr_r [2];
   logic [31:0] wd_r   [2];
   logic        busy_r [2];
   logic [31:0] resp_r [2][4];
   logic [4:0]  cevt_r [2];
   logic [2:0]  devt_r [2];

   logic [7:0]  dout_a;
   logic [31:0] dout_b, arg_a, arg_b;
   logic [13:0] cmd_a, cmd_b;
   logic [23:0] cto_a, cto_b, dto_a, dto_b;
   logic [11:0] bs_a, bs_b;
   logic [15:0] bc_a, bc_b;
   logic [7:0]  cd_a, cd_b;
   logic        ctl_a, ctl_b, swr_a, swr_b, cst_a, cst_b;
   logic        cir_a, cir_b, dir_a, dir_b, irq_a, irq_b;

   sd_regs_bus #(.BUS_W(8)) u_a (
      .clk_i(clk), .rst_i(rst), .we_i(we_r[0]), .re_i(re_r[0]), .addr_i(addr_r[0]),
      .data_in_i(wd_r[0][7:0]), .data_out_o(dout_a), .cmd_busy_i(busy_r[0]),
      .response_0_i(resp_r[0][0]), .response_1_i(resp_r[0][1]),
      .response_2_i(resp_r[0][2]), .response_3_i(resp_r[0][3]),
      .cmd_int_evt_i(cevt_r[0]), .data_int_evt_i(devt_r[0]),
      .argument_reg_o(arg_a), .command_reg_o(cmd_a), .cmd_timeout_reg_o(cto_a),
      .data_timeout_reg_o(dto_a), .block_size_reg_o(bs_a), .block_count_reg_o(bc_a),
      .clock_divider_reg_o(cd_a), .controll_setting_reg_o(ctl_a),
      .software_reset_reg_o(swr_a), .cmd_start_o(cst_a), .cmd_int_rst_o(cir_a),
      .data_int_rst_o(dir_a), .irq_o(irq_a));

   sd_regs_bus #(.BUS_W(32)) u_b (
      .clk_i(clk), .rst_i(rst), .we_i(we_r[1]), .re_i(re_r[1]), .addr_i(addr_r[1]),
      .data_in_i(wd_r[1]), .data_out_o(dout_b), .cmd_busy_i(busy_r[1]),
      .response_0_i(resp_r[1][0]), .response_1_i(resp_r[1][1]),
      .response_2_i(resp_r[1][2]), .response_3_i(resp_r[1][3]),
      .cmd_int_evt_i(cevt_r[1]), .data_int_evt_i(devt_r[1]),
      .argument_reg_o(arg_b), .command_reg_o(cmd_b), .cmd_timeout_reg_o(cto_b),
      .data_timeout_reg_o(dto_b), .block_size_reg_o(bs_b), .block_count_reg_o(bc_b),
      .clock_divider_reg_o(cd_b), .controll_setting_reg_o(ctl_b),
      .software_reset_reg_o(swr_b), .cmd_start_o(cst_b), .cmd_int_rst_o(cir_b),
      .data_int_rst_o(dir_b), .irq_o(irq_b));

   int checks = 0;
   int failures = 0;

   // Reference model: one 32-bit image per word offset, trimmed to the field width.
   logic [31:0] mv [2][32];
   logic [31:0] m_stage [2], m_snap [2], m_arg [2], m_dout [2];
   logic        m_cst [2], m_cir [2], m_dir [2], m_irq [2];
   obs_t q0 [$];
   obs_t q1 [$];

   function automatic logic [31:0] wmask(int w);
      case (w)
         1:       return 32'h0000_3FFF;
         6, 8:    return 32'h00FF_FFFF;
         7, 10:   return 32'h0000_0001;
         9:       return 32'h0000_00FF;
         13, 14:  return 32'h0000_001F;
         15, 16:  return 32'h0000_0007;
         17:      return 32'h0000_0FFF;
         18:      return 32'h0000_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rd_word(int d, int w, bit live);
      case (w)
         0:          return m_arg[d];
         2, 3, 4, 5: return live ? resp_r[d][w-2] : m_snap[d];
         11:         return 32'd3300;
         12:         return 32'h0;
         default:    return mv[d][w];
      endcase
   endfunction

   task automatic model_reset(int d);
      for (int w = 0; w < 32; w++) mv[d][w] = 32'h0;
      mv[d][17] = 32'd512;
      mv[d][9]  = 32'd1;
      m_stage[d] = 0; m_snap[d] = 0; m_arg[d] = 0; m_dout[d] = 0;
      m_cst[d] = 0; m_cir[d] = 0; m_dir[d] = 0; m_irq[d] = 0;
   endtask

   task automatic model_step(int d);
      int          lanes, w, off, b;
      logic [6:0]  base;
      logic [31:0] nd, word_v, clr13, clr15;
      logic [7:0]  bt;
      logic        commit, nirq;
      lanes = (d == 0) ? 1 : 4;
      base  = addr_r[d] & ~7'(lanes - 1);
      w     = int'(base[6:2]);
      off   = int'(base[1:0]);
      nirq  = (|(mv[d][13] & mv[d][14])) || (|(mv[d][15] & mv[d][16]));
      if (re_r[d]) begin
         nd = 0;
         word_v = rd_word(d, w, off == 0);
         for (int k = 0; k < lanes; k++) begin
            b = off + k;
            nd[8*k +: 8] = word_v[8*b +: 8];
         end
         m_dout[d] = nd;
         if (w >= 2 && w <= 5 && off == 0) m_snap[d] = resp_r[d][w-2];
      end
      clr13 = 0; clr15 = 0; commit = 0;
      if (we_r[d]) begin
         for (int k = 0; k < lanes; k++) begin
            b  = off + k;
            bt = wd_r[d][8*k +: 8];
            if (w == 0) begin
               m_stage[d][8*b +: 8] = bt;
               if (b == 3) commit = 1;
            end else if (w == 13) clr13[8*b +: 8] = bt;
            else if (w == 15) clr15[8*b +: 8] = bt;
            else if (wmask(w) != 0) mv[d][w][8*b +: 8] = bt;
         end
         mv[d][w] = mv[d][w] & wmask(w);
      end
      mv[d][13] = (mv[d][13] & ~clr13) | 32'(cevt_r[d]);
      mv[d][15] = (mv[d][15] & ~clr15) | 32'(devt_r[d]);
      if (commit) m_arg[d] = m_stage[d];
      m_cst[d] = commit && !busy_r[d];
      m_cir[d] = we_r[d] && (w == 13);
      m_dir[d] = we_r[d] && (w == 15);
      m_irq[d] = nirq;
   endtask

   function automatic obs_t exp_obs(int d);
      obs_t o;
      o.dout = m_dout[d];     o.arg = m_arg[d];
      o.cmd  = mv[d][1][13:0]; o.cto = mv[d][8][23:0]; o.dto = mv[d][6][23:0];
      o.bs   = mv[d][17][11:0]; o.bc = mv[d][18][15:0]; o.cd = mv[d][9][7:0];
      o.ctl  = mv[d][7][0];   o.swr = mv[d][10][0];
      o.cst  = m_cst[d]; o.cir = m_cir[d]; o.dir = m_dir[d]; o.irq = m_irq[d];
      return o;
   endfunction

   function automatic obs_t observe(int d);
      obs_t o;
      if (d == 0) begin
         o.dout = {24'h0, dout_a}; o.arg = arg_a; o.cmd = cmd_a; o.cto = cto_a; o.dto = dto_a;
         o.bs = bs_a; o.bc = bc_a; o.cd = cd_a; o.ctl = ctl_a; o.swr = swr_a;
         o.cst = cst_a; o.cir = cir_a; o.dir = dir_a; o.irq = irq_a;
      end else begin
         o.dout = dout_b; o.arg = arg_b; o.cmd = cmd_b; o.cto = cto_b; o.dto = dto_b;
         o.bs = bs_b; o.bc = bc_b; o.cd = cd_b; o.ctl = ctl_b; o.swr = swr_b;
         o.cst = cst_b; o.cir = cir_b; o.dir = dir_b; o.irq = irq_b;
      end
      return o;
   endfunction

   task automatic cmp(string nm, int d, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL sb_%s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
      end
   endtask

   task automatic compare(int d, obs_t e);
      obs_t o;
      o = observe(d);
      cmp("dout", d, 128'(o.dout), 128'(e.dout));
      cmp("arg", d, 128'(o.arg), 128'(e.arg));
      cmp("cfg", d, 128'({o.cmd, o.cto, o.dto, o.bs, o.bc, o.cd, o.ctl, o.swr}),
                    128'({e.cmd, e.cto, e.dto, e.bs, e.bc, e.cd, e.ctl, e.swr}));
      cmp("pulse_irq", d, 128'({o.cst, o.cir, o.dir, o.irq}), 128'({e.cst, e.cir, e.dir, e.irq}));
   endtask

   // Monitor: one expected snapshot per clock edge, compared half a cycle later.
   always @(negedge clk) begin
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      obs_t e0, e1;
      if (rst) begin model_reset(0); model_reset(1); end
      else begin model_step(0); model_step(1); end
      e0 = exp_obs(0);
      e1 = exp_obs(1);
      @(posedge clk);
      q0.push_back(e0);
      q1.push_back(e1);
      #1;
   endtask

   task automatic idle();
      for (int d = 0; d < 2; d++) begin
         we_r[d] = 0; re_r[d] = 0; cevt_r[d] = 0; devt_r[d] = 0;
      end
   endtask

   task automatic wr(int d, int a, logic [31:0] v);
      idle();
      we_r[d] = 1; addr_r[d] = 7'(a); wd_r[d] = v;
      cycle();
      we_r[d] = 0;
   endtask

   task automatic rd(int d, int a);
      idle();
      re_r[d] = 1; addr_r[d] = 7'(a);
      cycle();
      re_r[d] = 0;
   endtask

   initial begin
      rst = 1;
      for (int d = 0; d < 2; d++) begin
         addr_r[d] = 0; wd_r[d] = 0; busy_r[d] = 0;
         for (int r = 0; r < 4; r++) resp_r[d][r] = 0;
      end
      idle();
      cycle(); cycle();
      rst = 0;

      // Reset values through the 8-bit read path
      for (int a = 0; a < 80; a++) rd(0, a);
      rd(0, 'h44); chk("rst_blksize_b0", {24'h0, dout_a}, 32'h00);
      rd(0, 'h45); chk("rst_blksize_b1", {24'h0, dout_a}, 32'h02);
      rd(0, 'h24); chk("rst_clkdiv", {24'h0, dout_a}, 32'h01);
      rd(0, 'h2C); chk("rst_volt_b0", {24'h0, dout_a}, 32'hE4);
      rd(0, 'h2D); chk("rst_volt_b1", {24'h0, dout_a}, 32'h0C);
      rd(0, 'h04); chk("rst_cmd", {24'h0, dout_a}, 32'h00);

      // Staged argument, then commit with and without cmd_busy
      wr(0, 0, 32'h11); chk("stage0_nostart", 32'(cst_a), 0);
      wr(0, 1, 32'h22);
      wr(0, 2, 32'h33); chk("stage_arg_unchanged", arg_a, 32'h0);
      wr(0, 3, 32'h44); chk("commit_arg", arg_a, 32'h4433_2211);
      chk("commit_start", 32'(cst_a), 1);
      cycle(); chk("start_one_pulse", 32'(cst_a), 0);
      busy_r[0] = 1;
      wr(0, 0, 32'h55); wr(0, 1, 32'h66); wr(0, 2, 32'h77); wr(0, 3, 32'h88);
      chk("busy_commit_arg", arg_a, 32'h8877_6655);
      chk("busy_no_start", 32'(cst_a), 0);
      busy_r[0] = 0;
      cycle(); chk("busy_no_start_late", 32'(cst_a), 0);

      // Response snapshot
      resp_r[0][1] = 32'hAABB_CCDD;
      rd(0, 'h0C); chk("snap_b0_live", {24'h0, dout_a}, 32'hDD);
      resp_r[0][1] = 32'h1234_5678;
      rd(0, 'h0D); chk("snap_b1", {24'h0, dout_a}, 32'hCC);
      rd(0, 'h0E); chk("snap_b2", {24'h0, dout_a}, 32'hBB);
      rd(0, 'h0F); chk("snap_b3", {24'h0, dout_a}, 32'hAA);

      // Interrupt status, set-wins-over-clear, irq latency
      wr(0, 'h38, 32'h01);
      idle(); cevt_r[0] = 5'b00101; cycle(); cevt_r[0] = 0;
      chk("irq_lag1", 32'(irq_a), 0);
      cycle(); chk("irq_lag2", 32'(irq_a), 1);
      idle(); we_r[0] = 1; addr_r[0] = 7'h34; wd_r[0] = 32'h01; cevt_r[0] = 5'b00001;
      cycle(); idle();
      chk("isr_rst_pulse", 32'(cir_a), 1);
      rd(0, 'h34); chk("isr_set_wins", {24'h0, dout_a}, 32'h05);
      chk("isr_rst_once", 32'(cir_a), 0);
      wr(0, 'h34, 32'h05); chk("irq_still_high", 32'(irq_a), 1);
      cycle(); chk("irq_dropped", 32'(irq_a), 0);
      rd(0, 'h34); chk("isr_cleared", {24'h0, dout_a}, 32'h00);

      // 32-bit bus
      wr(1, 0, 32'hDEAD_BEEF); chk("w32_arg", arg_b, 32'hDEAD_BEEF);
      chk("w32_start", 32'(cst_b), 1);
      wr(1, 'h44, 32'hFFFF_FFFF); chk("w32_blksize", 32'(bs_b), 32'hFFF);
      chk("w32_start_once", 32'(cst_b), 0);
      rd(1, 'h2C); chk("w32_volt", dout_b, 32'd3300);

      // Reset in the middle of staging
      wr(0, 0, 32'h12); wr(0, 1, 32'h34);
      rst = 1; cycle(); rst = 0;
      wr(0, 3, 32'h9A); chk("rst_mid_stage", arg_a, 32'h9A00_0000);

      // Randomised traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         for (int d = 0; d < 2; d++) begin
            we_r[d]   = 1'($urandom_range(0, 1));
            re_r[d]   = 1'($urandom_range(0, 1));
            addr_r[d] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                    : 7'($urandom_range(0, 79));
            wd_r[d]   = $urandom;
            busy_r[d] = ($urandom_range(0, 3) == 0);
            cevt_r[d] = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'h0;
            devt_r[d] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'h0;
            if ($urandom_range(0, 7) == 0) resp_r[d][$urandom_range(0, 3)] = $urandom;
         end
         cycle();
      end
      rst = 0;
      idle();
      cycle(); cycle();
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sd_regs_bus.md
Name: sd_regs_bus

Overview:
- Parametrised register bank for the SD card controller, between the host bus and the command/data masters.
- Successor to the fixed 8-bit byte-lane register file, with these additions:
  - bus width selectable as 8, 16 or 32 bits;
  - atomic commit of the argument word;
  - snapshot reads of the response words;
  - sticky write-1-to-clear (W1C) interrupt status with enable masks and a registered irq;
  - registered read data.

Parameters:
- BUS_W, 8, host data width; legal values 8/16/32; LANES=BUS_W/8.
- CMD_W, 14, command register width.
- CMD_TIMEOUT_W, 24, command timeout width.
- DATA_TIMEOUT_W, 24, data timeout width.
- BLKSIZE_W, 12, block size width.
- BLKCNT_W, 16, block count width.
- INT_CMD_W, 5, command interrupt vector width.
- INT_DATA_W, 3, data interrupt vector width.
- RESET_BLOCK_SIZE, 512, reset value of blksize.
- SUPPLY_VOLTAGE_MV, 3300, read-only voltage register value.
- CAPABILITIES, 16'h0000, read-only capability value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- we  in  1  write strobe, one access per cycle
- re  in  1  read strobe
- addr  in  7  byte address; bits below log2(LANES) ignored
- data_in  in  BUS_W  write data, lane k = byte (addr aligned + k)
- data_out  out  BUS_W  read data, valid the cycle after re
- cmd_busy  in  1  command master busy
- response_0..3  in  32 each  response words
- cmd_int_evt  in  INT_CMD_W  one-cycle command event pulses
- data_int_evt  in  INT_DATA_W  one-cycle data event pulses
- argument_reg  out  32
- command_reg  out  CMD_W
- cmd_timeout_reg  out  CMD_TIMEOUT_W
- data_timeout_reg  out  DATA_TIMEOUT_W
- block_size_reg  out  BLKSIZE_W
- block_count_reg  out  BLKCNT_W
- clock_divider_reg  out  8
- controll_setting_reg  out  1
- software_reset_reg  out  1
- cmd_start  out  1  one-cycle start pulse
- cmd_int_rst  out  1  one-cycle pulse on any cmd_isr write
- data_int_rst  out  1  one-cycle pulse on any data_isr write
- irq  out  1  registered interrupt request

Behaviour:
- Reset and clocking: one clock, synchronous active-high rst.
  - Reset values: all config registers 0, except block_size_reg=RESET_BLOCK_SIZE and clock_divider_reg=1.
  - ISRs, ISERs, staging, snapshot, data_out, irq and all pulses reset to 0.
- Address map (word offsets), access as follows:
  - 0x00 argument: staged
  - 0x04 command, 0x18 data_timeout, 0x1C controller, 0x20 cmd_timeout, 0x24 clock_d, 0x28 reset: read/write
  - 0x08/0x0C/0x10/0x14 resp0-3: read-only, snapshot
  - 0x2C voltage, 0x30 capa: read-only
  - 0x34 cmd_isr, 0x3C data_isr: W1C
  - 0x38 cmd_iser, 0x40 data_iser: read/write
  - 0x44 blksize, 0x48 blkcnt: read/write
  - Unmapped: writes ignored, reads return 0.
- Writes:
  - Each lane writes its byte of the target register. Bits above the register width are dropped; a lane falling wholly above the width is ignored.
- Argument staging:
  - Lanes write a 32-bit staging register.
  - An access that includes byte 3 commits staging, with that access's lanes merged in, to argument_reg on the same edge.
  - cmd_start pulses on the following cycle.
  - A commit while cmd_busy=1 still updates argument_reg but suppresses cmd_start.
  - Writes that do not include byte 3 never start a command.
- Response snapshot:
  - A read whose lanes include byte 0 of respN loads snap <= response_N and returns the live bytes.
  - A read of respN that excludes byte 0 returns snap bytes.
  - At BUS_W=32 every read includes byte 0, so snapshot behaviour is transparent.
- Reads:
  - data_out updates only on cycles with re=1, else it holds.
  - Latency is exactly 1 cycle.
  - With we and re together, the read returns the pre-write value.
- Interrupt status (ISR):
  - Per bit: isr <= (isr & ~clr) | evt, where clr = W1C write data.
  - Set wins over a simultaneous clear.
  - Any write to an ISR pulses the matching *_int_rst next cycle.
- irq:
  - irq <= |(cmd_isr & cmd_iser) | |(data_isr & data_iser), computed from the registered ISR values.
  - irq therefore lags an event by 2 cycles.
- Soft reset:
  - software_reset_reg is an ordinary read/write bit exported to the core; it does not clear this block.
- Reset mid-operation:
  - rst clears partial staging and the snapshot.
  - A pending cmd_start is dropped.

Test Plan:
- Reset, then read each mapped register at BUS_W=8 → blksize=0x00/0x02 (bytes 0/1 of 0x200), clock_d=0x01, voltage=0xE4/0x0C, others 0.
- BUS_W=8: write 0x11,0x22,0x33 to 0x00..0x02 → no cmd_start, argument_reg unchanged. Write 0x44 to 0x03 → argument_reg=0x44332211 same edge, cmd_start one pulse next cycle. Repeat with cmd_busy=1 → argument updated, no pulse.
- response_1=0xAABBCCDD; read 0x0C; change response_1 to 0x12345678; read 0x0D..0x0F → 0xDD, 0xCC, 0xBB, 0xAA.
- cmd_int_evt=5'b00101 pulse, cmd_iser=1 → cmd_isr=0x05, irq=1 two cycles after the event. Write 0x01 to 0x34 with evt bit0 pulsed the same cycle → cmd_isr stays 0x05, cmd_int_rst pulses. Write 0x05 → isr=0, irq drops next cycle.
- BUS_W=32: single write 0xDEADBEEF to 0x00 → argument_reg=0xDEADBEEF, one cmd_start. Write 0xFFFF_FFFF to 0x44 → blksize=0xFFF.
- Assert rst after staging 2 argument bytes, then write byte 3 only → argument_reg = byte3<<24, upper staging zeroed.
